// File: rtl/cpu_bus_bridge.sv
// 68000 asynchronous bus handshake to synchronous chip-bus request bridge.
// Synchronises the CPU strobes, issues one slot request per _as cycle and ends it with _dtack or _berr.
module cpu_bus_bridge #(
    parameter int TIMEOUT = 1024,
    parameter int CNTW    = 10
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        _as,
    input  logic        _uds,
    input  logic        _lds,
    input  logic        r_w,
    input  logic [22:0] cpuaddr_in,
    input  logic [15:0] cpudata_in,
    output logic [15:0] cpudata_out,
    output logic        _dtack,
    output logic        _berr,
    output logic [22:0] cpuaddress,
    output logic        cpurd,
    output logic        cpuhwr,
    output logic        cpulwr,
    output logic [15:0] busdata_out,
    input  logic [15:0] busdata_in,
    input  logic        cpuok
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        REQ,
        ACK,
        BERR
    } state_t;

    state_t          state;
    state_t          next;
    logic [1:0]      as_sync;
    logic [1:0]      uds_sync;
    logic [1:0]      lds_sync;
    logic            as_s;
    logic            uds_s;
    logic            lds_s;
    logic            rw_q;
    logic [CNTW-1:0] counter;
    logic            in_req;
    logic            grant;
    logic            last_cycle;

    assign as_s  = as_sync[1];
    assign uds_s = uds_sync[1];
    assign lds_s = lds_sync[1];

    // Strobes are gated by as_s so an aborting CPU never presents a request to the arbiter.
    assign in_req     = (state == REQ) && !as_s;
    assign cpurd      = in_req && rw_q && !(uds_s && lds_s);
    assign cpuhwr     = in_req && !rw_q && !uds_s;
    assign cpulwr     = in_req && !rw_q && !lds_s;
    assign grant      = cpuok && (cpurd || cpuhwr || cpulwr);
    assign last_cycle = (counter == CNTW'(TIMEOUT - 1));

    always_comb begin
        next = state;
        case (state)
            IDLE: if (!as_s) next = ADDR;
            ADDR: begin
                if (as_s)                   next = IDLE;
                else if (r_w)               next = REQ;
                else if (!(uds_s && lds_s)) next = REQ;
            end
            REQ: begin
                if (as_s)            next = IDLE;
                else if (grant)      next = ACK;
                else if (last_cycle) next = BERR;
            end
            ACK:     if (as_s) next = IDLE;
            BERR:    if (as_s) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state       <= IDLE;
            as_sync     <= '1;
            uds_sync    <= '1;
            lds_sync    <= '1;
            _dtack      <= 1'b1;
            _berr       <= 1'b1;
            cpuaddress  <= '0;
            cpudata_out <= '0;
            busdata_out <= '0;
            counter     <= '0;
            rw_q        <= 1'b1;
        end else begin
            as_sync  <= {as_sync[0], _as};
            uds_sync <= {uds_sync[0], _uds};
            lds_sync <= {lds_sync[0], _lds};
            state    <= next;
            _dtack   <= (next != ACK);
            _berr    <= (next != BERR);

            if (state == IDLE && !as_s)
                cpuaddress <= cpuaddr_in;

            if (state == ADDR && next == REQ) begin
                rw_q <= r_w;
                if (!r_w)
                    busdata_out <= cpudata_in;
            end

            if (state == REQ && grant && rw_q)
                cpudata_out <= busdata_in;

            if (state != REQ)
                counter <= '0;
            else if (next == REQ)
                counter <= counter + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge with TIMEOUT=16; every expectation is a hand-computed constant.
module tb_cpu_bus_bridge;

    logic        clk = 1'b0;
    logic        _reset;
    logic        _as, _uds, _lds, r_w;
    logic [22:0] cpuaddr_in;
    logic [15:0] cpudata_in;
    logic [15:0] cpudata_out;
    logic        _dtack, _berr;
    logic [22:0] cpuaddress;
    logic        cpurd, cpuhwr, cpulwr;
    logic [15:0] busdata_out;
    logic [15:0] busdata_in;
    logic        cpuok;

    int checks   = 0;
    int failures = 0;

    cpu_bus_bridge #(.TIMEOUT(16), .CNTW(10)) dut (
        .clk(clk), ._reset(_reset), ._as(_as), ._uds(_uds), ._lds(_lds), .r_w(r_w),
        .cpuaddr_in(cpuaddr_in), .cpudata_in(cpudata_in), .cpudata_out(cpudata_out),
        ._dtack(_dtack), ._berr(_berr), .cpuaddress(cpuaddress), .cpurd(cpurd),
        .cpuhwr(cpuhwr), .cpulwr(cpulwr), .busdata_out(busdata_out),
        .busdata_in(busdata_in), .cpuok(cpuok)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cycle(input logic [22:0] a, input logic rw, input logic u,
                               input logic l, input logic [15:0] d);
        cpuaddr_in = a;
        r_w        = rw;
        cpudata_in = d;
        _uds       = u;
        _lds       = l;
        _as        = 1'b0;
    endtask

    task automatic release_cycle();
        _as  = 1'b1;
        _uds = 1'b1;
        _lds = 1'b1;
        r_w  = 1'b1;
    endtask

    task automatic test_reset();
        _reset = 1'b0;
        release_cycle();
        cpuaddr_in = 23'h7FFFFF;
        cpudata_in = 16'hFFFF;
        busdata_in = 16'h0000;
        cpuok      = 1'b0;
        tick();
        tick();
        checks++;
        if ({_dtack, _berr, cpurd, cpuhwr, cpulwr} !== 5'b11000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=11000", {_dtack, _berr, cpurd, cpuhwr, cpulwr});
        end
        checks++;
        if ({cpuaddress, cpudata_out, busdata_out} !== 55'd0) begin
            failures++;
            $display("FAIL reset_data addr=%h rd=%h wr=%h want all 0", cpuaddress, cpudata_out, busdata_out);
        end
        _reset = 1'b1;
        tick();
    endtask

    task automatic test_read_immediate();
        busdata_in = 16'hBEEF;
        cpuok      = 1'b1;
        start_cycle(23'h000400, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(); tick(); tick();
        checks++;
        if (cpurd !== 1'b0 || cpuaddress !== 23'h000400) begin
            failures++;
            $display("FAIL rd_addr_phase cpurd=%b addr=%h want cpurd=0 addr=000400", cpurd, cpuaddress);
        end
        tick();
        checks++;
        if (cpurd !== 1'b1 || _dtack !== 1'b1) begin
            failures++;
            $display("FAIL rd_latency cpurd=%b dtack=%b want 1 1", cpurd, _dtack);
        end
        tick();
        checks++;
        if (cpurd !== 1'b0 || _dtack !== 1'b0 || cpudata_out !== 16'hBEEF) begin
            failures++;
            $display("FAIL rd_ack cpurd=%b dtack=%b data=%h want 0 0 beef", cpurd, _dtack, cpudata_out);
        end
        cpuok = 1'b0;
        release_cycle();
        tick(); tick();
        checks++;
        if (_dtack !== 1'b0) begin
            failures++;
            $display("FAIL rd_dtack_hold dtack=%b want 0", _dtack);
        end
        tick();
        checks++;
        if (_dtack !== 1'b1 || _berr !== 1'b1) begin
            failures++;
            $display("FAIL rd_release dtack=%b berr=%b want 1 1", _dtack, _berr);
        end
        tick();
    endtask

    task automatic test_byte_write_wait();
        int bad = 0;
        cpuok = 1'b0;
        start_cycle(23'h012345, 1'b0, 1'b1, 1'b0, 16'h00A5);
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 8; i++) begin
            if (cpulwr !== 1'b1 || cpuhwr !== 1'b0 || cpurd !== 1'b0 || _dtack !== 1'b1) bad++;
            if (i < 7) tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bwr_strobes bad_cycles=%0d want 0", bad);
        end
        checks++;
        if (busdata_out !== 16'h00A5 || cpuaddress !== 23'h012345) begin
            failures++;
            $display("FAIL bwr_latch data=%h addr=%h want 00a5 012345", busdata_out, cpuaddress);
        end
        cpuok = 1'b1;
        tick();
        cpuok = 1'b0;
        checks++;
        if (cpulwr !== 1'b0 || _dtack !== 1'b0 || busdata_out !== 16'h00A5) begin
            failures++;
            $display("FAIL bwr_ack lwr=%b dtack=%b data=%h want 0 0 00a5", cpulwr, _dtack, busdata_out);
        end
        release_cycle();
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_word_write();
        cpuok = 1'b0;
        start_cycle(23'h000100, 1'b0, 1'b0, 1'b0, 16'h3C5A);
        tick(); tick(); tick(); tick();
        checks++;
        if ({cpuhwr, cpulwr, cpurd} !== 3'b110 || busdata_out !== 16'h3C5A) begin
            failures++;
            $display("FAIL wwr_strobes hwr/lwr/rd=%b data=%h want 110 3c5a", {cpuhwr, cpulwr, cpurd}, busdata_out);
        end
        cpuok = 1'b1;
        tick();
        cpuok = 1'b0;
        checks++;
        if ({cpuhwr, cpulwr} !== 2'b00 || _dtack !== 1'b0) begin
            failures++;
            $display("FAIL wwr_ack hwr/lwr=%b dtack=%b want 00 0", {cpuhwr, cpulwr}, _dtack);
        end
        release_cycle();
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_timeout();
        int bad = 0;
        cpuok = 1'b0;
        start_cycle(23'h7F0000, 1'b1, 1'b0, 1'b1, 16'h0000);
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 16; i++) begin
            if (cpurd !== 1'b1 || _berr !== 1'b1) bad++;
            if (i < 15) tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL to_req_cycles bad_cycles=%0d want 0", bad);
        end
        tick();
        checks++;
        if (cpurd !== 1'b0 || _berr !== 1'b0 || _dtack !== 1'b1) begin
            failures++;
            $display("FAIL to_berr cpurd=%b berr=%b dtack=%b want 0 0 1", cpurd, _berr, _dtack);
        end
        release_cycle();
        tick(); tick();
        checks++;
        if (_berr !== 1'b0) begin
            failures++;
            $display("FAIL to_berr_hold berr=%b want 0", _berr);
        end
        tick();
        checks++;
        if (_berr !== 1'b1 || _dtack !== 1'b1) begin
            failures++;
            $display("FAIL to_release berr=%b dtack=%b want 1 1", _berr, _dtack);
        end
        tick();
    endtask

    task automatic test_grant_on_timeout_edge();
        busdata_in = 16'h1234;
        cpuok      = 1'b0;
        start_cycle(23'h000002, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (cpurd !== 1'b1) begin
            failures++;
            $display("FAIL edge_req cpurd=%b want 1", cpurd);
        end
        cpuok = 1'b1;
        tick();
        cpuok = 1'b0;
        checks++;
        if (_dtack !== 1'b0 || _berr !== 1'b1 || cpudata_out !== 16'h1234) begin
            failures++;
            $display("FAIL edge_ack dtack=%b berr=%b data=%h want 0 1 1234", _dtack, _berr, cpudata_out);
        end
        release_cycle();
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_abort();
        int dtk = 0;
        cpuok = 1'b0;
        start_cycle(23'h000800, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(); tick(); tick(); tick(); tick(); tick();
        release_cycle();
        tick(); tick();
        checks++;
        if (cpurd !== 1'b0) begin
            failures++;
            $display("FAIL abort_strobe cpurd=%b want 0", cpurd);
        end
        for (int i = 0; i < 4; i++) begin
            if (_dtack !== 1'b1 || _berr !== 1'b1) dtk++;
            tick();
        end
        checks++;
        if (dtk != 0) begin
            failures++;
            $display("FAIL abort_no_term bad_cycles=%0d want 0", dtk);
        end
        busdata_in = 16'h5A5A;
        cpuok      = 1'b1;
        start_cycle(23'h000810, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(); tick(); tick(); tick(); tick();
        cpuok = 1'b0;
        checks++;
        if (_dtack !== 1'b0 || cpudata_out !== 16'h5A5A || cpuaddress !== 23'h000810) begin
            failures++;
            $display("FAIL abort_next_read dtack=%b data=%h addr=%h want 0 5a5a 000810", _dtack, cpudata_out, cpuaddress);
        end
        release_cycle();
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_tas_single_transfer();
        int extra = 0;
        busdata_in = 16'h0080;
        cpuok      = 1'b1;
        start_cycle(23'h000040, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick(); tick(); tick(); tick(); tick();
        checks++;
        if (_dtack !== 1'b0 || cpudata_out !== 16'h0080) begin
            failures++;
            $display("FAIL tas_read dtack=%b data=%h want 0 0080", _dtack, cpudata_out);
        end
        _lds = 1'b1;
        tick(); tick(); tick();
        r_w        = 1'b0;
        cpudata_in = 16'h0080;
        _lds       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (cpurd || cpuhwr || cpulwr) extra++;
            tick();
        end
        cpuok = 1'b0;
        checks++;
        if (extra != 0 || _dtack !== 1'b0) begin
            failures++;
            $display("FAIL tas_no_second extra=%0d dtack=%b want 0 0", extra, _dtack);
        end
        release_cycle();
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_cycle();
        busdata_in = 16'hCAFE;
        cpuok      = 1'b1;
        start_cycle(23'h000123, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(); tick(); tick(); tick(); tick();
        checks++;
        if (_dtack !== 1'b0 || cpudata_out !== 16'hCAFE) begin
            failures++;
            $display("FAIL rst_pre dtack=%b data=%h want 0 cafe", _dtack, cpudata_out);
        end
        #2 _reset = 1'b0;
        #1;
        checks++;
        if (_dtack !== 1'b1 || cpudata_out !== 16'h0000 || {cpurd, cpuhwr, cpulwr} !== 3'b000 || cpuaddress !== 23'h0) begin
            failures++;
            $display("FAIL rst_async dtack=%b data=%h strobes=%b addr=%h want 1 0000 000 0",
                     _dtack, cpudata_out, {cpurd, cpuhwr, cpulwr}, cpuaddress);
        end
        release_cycle();
        cpuok = 1'b0;
        tick(); tick();
        _reset = 1'b1;
        tick(); tick();
        busdata_in = 16'h0F0F;
        cpuok      = 1'b1;
        start_cycle(23'h000456, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(); tick(); tick(); tick(); tick();
        cpuok = 1'b0;
        checks++;
        if (_dtack !== 1'b0 || cpudata_out !== 16'h0F0F) begin
            failures++;
            $display("FAIL rst_resume dtack=%b data=%h want 0 0f0f", _dtack, cpudata_out);
        end
        release_cycle();
        tick(); tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_read_immediate();
        test_byte_write_wait();
        test_word_write();
        test_timeout();
        test_grant_on_timeout_edge();
        test_abort();
        test_tas_single_transfer();
        test_reset_mid_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
